// File: rtl/multi_counter_pkg.sv
// Shared types for the multi-channel counter: command opcodes, channel states
// and the bit positions inside the per-channel mode field.
package multi_counter_pkg;

  localparam int unsigned OP_W          = 2;
  localparam int unsigned STATE_W       = 2;
  localparam int unsigned MODE_W        = 2;
  localparam int unsigned MODE_DIR_BIT  = 0;
  localparam int unsigned MODE_WRAP_BIT = 1;

  typedef enum logic [OP_W-1:0] {
    OP_INIT  = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } ch_state_e;

endpackage

// File: rtl/counter_channel.sv
// One counter channel: count, mode, sticky wrap flag, lifecycle FSM and the
// terminal-count pulse. Commands arrive already decoded and qualified by hit.
module counter_channel
  import multi_counter_pkg::*;
#(
  parameter int unsigned COUNT_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hit,
  input  op_e                op,
  input  logic [COUNT_W-1:0] data,
  input  logic [MODE_W-1:0]  mode,
  output logic [COUNT_W-1:0] count,
  output logic               wrapped,
  output ch_state_e          state,
  output logic               tc_pulse
);

  localparam logic [COUNT_W-1:0] ALL_ONES = '1;

  ch_state_e          state_d;
  logic [COUNT_W-1:0] count_d;
  logic [MODE_W-1:0]  mode_q;
  logic [MODE_W-1:0]  mode_d;
  logic               wrapped_d;
  logic               tc_d;
  logic               wrap_evt;

  logic               dir_down;
  logic               wrap_en;
  logic [COUNT_W-1:0] step_val;
  logic               at_wrap;
  logic               step_term;

  assign dir_down  = mode_q[MODE_DIR_BIT];
  assign wrap_en   = mode_q[MODE_WRAP_BIT];
  assign step_val  = dir_down ? (count - COUNT_W'(1)) : (count + COUNT_W'(1));
  assign at_wrap   = dir_down ? (count == '0) : (count == ALL_ONES);
  // Saturation looks only at the value being produced, so a channel loaded
  // with a terminal value steps off it rather than holding immediately.
  assign step_term = dir_down ? (step_val == '0) : (step_val == ALL_ONES);

  always_comb begin
    state_d   = state;
    count_d   = count;
    mode_d    = mode_q;
    wrapped_d = wrapped;
    tc_d      = 1'b0;
    wrap_evt  = 1'b0;

    if (hit && (op == OP_INIT)) begin
      count_d   = data;
      mode_d    = mode;
      wrapped_d = 1'b0;
      state_d   = ST_LOADED;
    end else begin
      // A STOP landing on a running channel freezes this edge's count.
      if ((state == ST_RUN) && !(hit && (op == OP_STOP))) begin
        count_d = step_val;
        if (wrap_en) begin
          if (at_wrap) begin
            wrap_evt  = 1'b1;
            tc_d      = 1'b1;
            wrapped_d = 1'b1;
          end
        end else if (step_term) begin
          tc_d    = 1'b1;
          state_d = ST_HOLD;
        end
      end

      if (hit) begin
        case (op)
          OP_START: if (state == ST_LOADED) state_d = ST_RUN;
          OP_STOP:  if (state == ST_RUN) state_d = ST_LOADED;
          OP_READ:  if (!wrap_evt) wrapped_d = 1'b0;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      mode_q   <= '0;
      wrapped  <= 1'b0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      mode_q   <= mode_d;
      wrapped  <= wrapped_d;
      tc_pulse <= tc_d;
    end
  end

endmodule

// File: rtl/multi_counter.sv
// Multi-channel counter top: command handshake and decode, per-channel
// instances, read mux and a single-entry response register.
module multi_counter
  import multi_counter_pkg::*;
#(
  parameter int unsigned COUNT_W = 64,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [COUNT_W-1:0]   cmd_data,
  input  logic [MODE_W-1:0]    cmd_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CH_W-1:0]      rsp_ch,
  output logic [COUNT_W-1:0]   rsp_count,
  output logic                 rsp_wrapped,
  output logic [NCH-1:0]       tc_pulse,
  output logic [2*NCH-1:0]     debug_state
);

  logic               accept;
  op_e                op;
  logic [NCH-1:0]     hit;
  logic [COUNT_W-1:0] count_a   [NCH];
  logic               wrapped_a [NCH];
  ch_state_e          state_a   [NCH];
  logic [COUNT_W-1:0] sel_count;
  logic               sel_wrapped;

  // Commands stall only while a response is waiting to be consumed.
  assign cmd_ready = !(rsp_valid && !rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign op        = op_e'(cmd_op);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i] = accept && (cmd_ch == CH_W'(i));
    assign debug_state[STATE_W*i +: STATE_W] = state_a[i];

    counter_channel #(
      .COUNT_W (COUNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .hit      (hit[i]),
      .op       (op),
      .data     (cmd_data),
      .mode     (cmd_mode),
      .count    (count_a[i]),
      .wrapped  (wrapped_a[i]),
      .state    (state_a[i]),
      .tc_pulse (tc_pulse[i])
    );
  end

  // Out-of-range channel numbers read back as an idle, zeroed channel.
  always_comb begin
    sel_count   = '0;
    sel_wrapped = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cmd_ch == CH_W'(i)) begin
        sel_count   = count_a[i];
        sel_wrapped = wrapped_a[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_ch      <= '0;
      rsp_count   <= '0;
      rsp_wrapped <= 1'b0;
    end else if (accept && (op == OP_READ)) begin
      rsp_valid   <= 1'b1;
      rsp_ch      <= cmd_ch;
      rsp_count   <= sel_count;
      rsp_wrapped <= sel_wrapped;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter (8-bit counts, 5 channels so that channel
// numbers 5..7 are out of range); read responses checked through a scoreboard.
module tb_multi_counter;

  localparam int unsigned CW  = 8;
  localparam int unsigned N   = 5;
  localparam int unsigned CHW = 3;

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;
  localparam logic [1:0] READ  = 2'd3;

  localparam logic [1:0] UP_SAT   = 2'b00;
  localparam logic [1:0] DN_SAT   = 2'b01;
  localparam logic [1:0] UP_WRAP  = 2'b10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = '0;
  logic [CHW-1:0] cmd_ch = '0;
  logic [CW-1:0]  cmd_data = '0;
  logic [1:0]     cmd_mode = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [CHW-1:0] rsp_ch;
  logic [CW-1:0]  rsp_count;
  logic           rsp_wrapped;
  logic [N-1:0]   tc_pulse;
  logic [2*N-1:0] debug_state;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [CW-1:0]  cnt;
    logic           wr;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  multi_counter #(.COUNT_W(CW), .NCH(N), .CH_W(CHW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_ch      (cmd_ch),
    .cmd_data    (cmd_data),
    .cmd_mode    (cmd_mode),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_ch      (rsp_ch),
    .rsp_count   (rsp_count),
    .rsp_wrapped (rsp_wrapped),
    .tc_pulse    (tc_pulse),
    .debug_state (debug_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed response is compared with the oldest expectation.
  always @(negedge clk) begin
    rsp_t a;
    rsp_t e;
    if (reset && rsp_valid && rsp_ready) begin
      a = '{ch: rsp_ch, cnt: rsp_count, wr: rsp_wrapped};
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got %0h expected none", a);
      end else begin
        e = sb.pop_front();
        check("rsp", 32'(a), 32'(e));
      end
    end
  end

  // Drive one command and hold it until accepted; READs push their expectation.
  task automatic issue(input logic [1:0] op, input logic [CHW-1:0] ch, input logic [CW-1:0] data,
                       input logic [1:0] mode, input logic [CW-1:0] exp_cnt, input logic exp_wr);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_data  = data;
    cmd_mode  = mode;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    if (op == READ) sb.push_back('{ch: ch, cnt: exp_cnt, wr: exp_wr});
    #1 cmd_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [CHW-1:0] ch, input logic [CW-1:0] data,
                     input logic [1:0] mode);
    issue(op, ch, data, mode, '0, 1'b0);
  endtask

  task automatic rd(input logic [CHW-1:0] ch, input logic [CW-1:0] exp_cnt, input logic exp_wr);
    issue(READ, ch, '0, 2'b00, exp_cnt, exp_wr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic watch_tc(input int ch, input int cycles, output int npulse, output int first);
    npulse = 0;
    first  = -1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tc_pulse[ch]) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int fp;

    // Reset state
    #12;
    check("reset_debug", 32'(debug_state), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk) reset = 1'b1;
    rd(3'd0, 8'd0, 1'b0);

    // Up/saturate: 75 + 10 steps, then STOP at 100 and resume
    cmd(INIT, 3'd0, 8'd75, UP_SAT);
    cmd(START, 3'd0, '0, '0);
    idle(10);
    rd(3'd0, 8'd85, 1'b0);
    idle(14);
    cmd(STOP, 3'd0, '0, '0);
    rd(3'd0, 8'd100, 1'b0);
    cmd(START, 3'd0, '0, '0);
    idle(1);
    rd(3'd0, 8'd101, 1'b0);
    cmd(STOP, 3'd0, '0, '0);

    // Down/saturate from 3: one pulse on reaching 0, then HOLD
    cmd(INIT, 3'd1, 8'd3, DN_SAT);
    cmd(START, 3'd1, '0, '0);
    watch_tc(1, 8, np, fp);
    check("ch1_tc_count", 32'(np), 32'd1);
    check("ch1_tc_cycle", 32'(fp), 32'd2 + 32'd1);
    check("ch1_hold", 32'(debug_state[3:2]), 32'd3);
    rd(3'd1, 8'd0, 1'b0);

    // Up/wrap from 254: pulse on wrap, sticky flag cleared by READ
    cmd(INIT, 3'd2, 8'd254, UP_WRAP);
    cmd(START, 3'd2, '0, '0);
    watch_tc(2, 8, np, fp);
    check("ch2_tc_count", 32'(np), 32'd1);
    check("ch2_tc_cycle", 32'(fp), 32'd2);
    cmd(STOP, 3'd2, '0, '0);
    rd(3'd2, 8'd6, 1'b1);
    rd(3'd2, 8'd6, 1'b0);

    // READ on the wrap edge does not clear the flag set by that wrap
    cmd(INIT, 3'd2, 8'd254, UP_WRAP);
    cmd(START, 3'd2, '0, '0);
    idle(1);
    rd(3'd2, 8'd255, 1'b0);
    cmd(STOP, 3'd2, '0, '0);
    rd(3'd2, 8'd0, 1'b1);
    rd(3'd2, 8'd0, 1'b0);

    // Out-of-range channel: INIT ignored, READ returns zero
    cmd(INIT, 3'd6, 8'd9, UP_SAT);
    check("oor_init_ignored", 32'(debug_state), 32'h01D);
    rd(3'd6, 8'd0, 1'b0);

    // Response backpressure stalls commands and holds rsp fields
    cmd(INIT, 3'd3, 8'd42, UP_SAT);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    rd(3'd3, 8'd42, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = INIT;
    cmd_ch    = 3'd3;
    cmd_data  = 8'd7;
    cmd_mode  = UP_SAT;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", 32'(cmd_ready), 32'h0);
      check("stall_rsp", 32'({rsp_valid, rsp_ch, rsp_count}), 32'({1'b1, 3'd3, 8'd42}));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rd(3'd3, 8'd7, 1'b0);

    // Asynchronous reset mid-cycle with channels 0 and 3 running
    cmd(INIT, 3'd0, 8'd10, UP_SAT);
    cmd(START, 3'd0, '0, '0);
    cmd(INIT, 3'd3, 8'd20, UP_SAT);
    cmd(START, 3'd3, '0, '0);
    idle(3);
    check("pre_reset_debug", 32'(debug_state), 32'h09E);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    rd(3'd0, 8'd0, 1'b0);
    #3 reset = 1'b0;
    sb.delete();
    #1;
    check("arst_rsp", 32'({rsp_valid, rsp_ch, rsp_count, rsp_wrapped}), 32'h0);
    check("arst_tc", 32'(tc_pulse), 32'h0);
    check("arst_debug", 32'(debug_state), 32'h0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    rd(3'd0, 8'd0, 1'b0);
    rd(3'd3, 8'd0, 1'b0);

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
